// File: rtl/dll_tap_ctrl.sv
// dll_tap_ctrl: DLL delay-line tap search and tracking controller with registered select/enable decode
module dll_tap_ctrl #(
  parameter int NUM_TAPS   = 64,
  parameter int TAP_W      = 6,
  parameter int SETTLE_CYC = 8,
  parameter int FILTER_LEN = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                start,
  input  logic                pd_valid,
  input  logic                pd_lead,
  output logic [TAP_W-1:0]    tap,
  output logic [NUM_TAPS-1:0] sel_n,
  output logic [NUM_TAPS-1:0] en,
  output logic                busy,
  output logic                locked,
  output logic                err
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [TAP_W-1:0] MAX_TAP = TAP_W'(NUM_TAPS - 1);
  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, LOCKED, ERROR} state_t;
  state_t state;
  logic trk;
  logic [SW-1:0] settle_cnt;
  logic [CW-1:0] lead_cnt, lag_cnt;
  logic lead_hit, lag_hit, at_max, at_min;
  function automatic logic [NUM_TAPS-1:0] sel_of(input logic [TAP_W-1:0] t);
    return ~(NUM_TAPS'(1) << t);
  endfunction
  function automatic logic [NUM_TAPS-1:0] en_of(input logic [TAP_W-1:0] t);
    return ~({NUM_TAPS{1'b1}} << t << 1);
  endfunction
  always_comb begin
    lead_hit = pd_valid & pd_lead & (lead_cnt == CW'(FILTER_LEN - 1));
    lag_hit  = pd_valid & ~pd_lead & (lag_cnt == CW'(FILTER_LEN - 1));
    at_max   = tap == MAX_TAP;
    at_min   = tap == '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      trk        <= 1'b0;
      tap        <= '0;
      sel_n      <= sel_of('0);
      en         <= en_of('0);
      busy       <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      settle_cnt <= '0;
      lead_cnt   <= '0;
      lag_cnt    <= '0;
    end else if (!enable) begin
      state      <= IDLE;
      busy       <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      settle_cnt <= '0;
      lead_cnt   <= '0;
      lag_cnt    <= '0;
    end else if (start && (state == IDLE || state == ERROR)) begin
      state      <= SETTLE;
      trk        <= 1'b0;
      tap        <= '0;
      sel_n      <= sel_of('0);
      en         <= en_of('0);
      busy       <= 1'b1;
      locked     <= 1'b0;
      err        <= 1'b0;
      settle_cnt <= '0;
    end else begin
      case (state)
        SETTLE: begin
          if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
            state      <= trk ? LOCKED : SAMPLE;
            settle_cnt <= '0;
            lead_cnt   <= '0;
            lag_cnt    <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        SAMPLE, LOCKED: begin
          if (lead_hit || lag_hit) begin
            lead_cnt <= '0;
            lag_cnt  <= '0;
            if ((lead_hit && at_max) || (lag_hit && at_min)) begin
              state  <= ERROR;
              err    <= 1'b1;
              busy   <= 1'b0;
              locked <= 1'b0;
            end else if (lead_hit) begin
              tap   <= tap + 1'b1;
              sel_n <= sel_of(tap + 1'b1);
              en    <= en_of(tap + 1'b1);
              state <= SETTLE;
            end else if (state == LOCKED) begin
              tap   <= tap - 1'b1;
              sel_n <= sel_of(tap - 1'b1);
              en    <= en_of(tap - 1'b1);
              state <= SETTLE;
            end else begin
              locked <= 1'b1;
              busy   <= 1'b0;
              trk    <= 1'b1;
              state  <= LOCKED;
            end
          end else if (pd_valid) begin
            lead_cnt <= pd_lead ? lead_cnt + 1'b1 : '0;
            lag_cnt  <= pd_lead ? '0 : lag_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dll_tap_ctrl.sv
// tb_dll_tap_ctrl: directed plus randomized check of dll_tap_ctrl against a streak/timer reference model
module tb_dll_tap_ctrl;
  localparam int N = 64;
  localparam int TW = 6;
  localparam int S = 8;
  localparam int F = 4;
  logic clk = 0, rst_n = 0, enable = 0, start = 0, pd_valid = 0, pd_lead = 0;
  logic [TW-1:0] tap;
  logic [N-1:0] sel_n, en;
  logic busy, locked, err;
  int checks = 0, errors = 0;
  int m_tap = 0, m_hold = 0, m_streak = 0, bias = 50;
  bit m_busy = 0, m_locked = 0, m_err = 0, m_idle = 1;
  logic [0:7] pat = 8'b11101111;
  dll_tap_ctrl #(.NUM_TAPS(N), .TAP_W(TW), .SETTLE_CYC(S), .FILTER_LEN(F)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .pd_valid(pd_valid), .pd_lead(pd_lead),
    .tap(tap), .sel_n(sel_n), .en(en), .busy(busy), .locked(locked), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [N-1:0] exp_en(input int t);
    logic [N-1:0] v = '0;
    for (int i = 0; i <= t; i++) v[i] = 1'b1;
    return v;
  endfunction
  function automatic logic [N-1:0] exp_sel(input int t);
    logic [N-1:0] v = '1;
    v[t] = 1'b0;
    return v;
  endfunction
  task automatic go_err();
    m_err = 1;
    m_busy = 0;
    m_locked = 0;
  endtask
  task automatic model_edge();
    if (!rst_n) begin
      m_tap = 0; m_busy = 0; m_locked = 0; m_err = 0; m_idle = 1; m_hold = 0; m_streak = 0;
    end else if (!enable) begin
      m_idle = 1; m_busy = 0; m_locked = 0; m_err = 0; m_hold = 0; m_streak = 0;
    end else if (start && (m_idle || m_err)) begin
      m_tap = 0; m_err = 0; m_locked = 0; m_busy = 1; m_idle = 0; m_hold = S; m_streak = 0;
    end else if (m_hold > 0) begin
      m_hold--;
      m_streak = 0;
    end else if (!m_idle && !m_err && pd_valid) begin
      m_streak = pd_lead ? (m_streak > 0 ? m_streak + 1 : 1) : (m_streak < 0 ? m_streak - 1 : -1);
      if (m_streak == F) begin
        m_streak = 0;
        if (m_tap == N - 1) go_err();
        else begin m_tap++; m_hold = S; end
      end else if (m_streak == -F) begin
        m_streak = 0;
        if (m_tap == 0) go_err();
        else if (m_locked) begin m_tap--; m_hold = S; end
        else begin m_locked = 1; m_busy = 0; end
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("tap", 64'(tap), 64'(m_tap));
    check("sel_n", sel_n, exp_sel(m_tap));
    check("en", en, exp_en(m_tap));
    check("busy", 64'(busy), 64'(m_busy));
    check("locked", 64'(locked), 64'(m_locked));
    check("err", 64'(err), 64'(m_err));
  endtask
  initial begin
    rst_n = 0; enable = 1;
    step(); step();
    rst_n = 1;
    repeat (3) step();
    check("rst_tap", 64'(tap), 64'd0);
    check("rst_sel", sel_n, 64'hFFFF_FFFF_FFFF_FFFE);
    check("rst_en", en, 64'h1);
    check("rst_flags", 64'({busy, locked, err}), 64'd0);
    start = 1; pd_valid = 1; pd_lead = 1;
    step();
    start = 0;
    for (int i = 0; i < 136 && !locked; i++) begin
      pd_lead = m_tap < 10;
      step();
    end
    check("acq_locked", 64'(locked), 64'd1);
    check("acq_tap", 64'(tap), 64'd10);
    check("acq_en", en, 64'h7FF);
    check("acq_sel", sel_n, ~64'h400);
    check("acq_busy", 64'(busy), 64'd0);
    pd_lead = 0;
    repeat (F) step();
    check("trk_dn", 64'(tap), 64'd9);
    check("trk_dn_lock", 64'(locked), 64'd1);
    pd_lead = 1;
    repeat (S) step();
    check("trk_settle", 64'(tap), 64'd9);
    repeat (F) step();
    check("trk_up", 64'(tap), 64'd10);
    check("trk_up_lock", 64'(locked), 64'd1);
    pd_valid = 0;
    enable = 0;
    step();
    enable = 1; start = 1; pd_valid = 1; pd_lead = 1;
    step();
    start = 0;
    for (int i = 0; i < 100 && !(m_tap == 5 && m_hold == 0); i++) step();
    check("glt_start", 64'(tap), 64'd5);
    for (int k = 0; k < 8; k++) begin
      pd_valid = 1; pd_lead = pat[k];
      step();
      if (k == 6) check("glt_hold", 64'(tap), 64'd5);
      pd_valid = 0; pd_lead = 1'($urandom_range(0, 1));
      step();
    end
    check("glt_step", 64'(tap), 64'd6);
    pd_valid = 1; pd_lead = 1;
    for (int i = 0; i < 800 && !err; i++) step();
    check("ovf_err", 64'(err), 64'd1);
    check("ovf_tap", 64'(tap), 64'd63);
    check("ovf_busy", 64'(busy), 64'd0);
    start = 1; pd_lead = 0;
    step();
    start = 0;
    check("unf_clr", 64'(err), 64'd0);
    for (int i = 0; i < 40 && !err; i++) step();
    check("unf_err", 64'(err), 64'd1);
    check("unf_tap", 64'(tap), 64'd0);
    start = 1; pd_lead = 1;
    step();
    start = 0;
    for (int i = 0; i < 120 && m_tap != 7; i++) step();
    repeat (3) step();
    enable = 0; start = 1;
    step();
    check("abt_busy", 64'(busy), 64'd0);
    check("abt_tap", 64'(tap), 64'd7);
    check("abt_en", en, 64'hFF);
    enable = 1; start = 0;
    step();
    check("abt_idle", 64'(tap), 64'd7);
    start = 1;
    step();
    start = 0;
    repeat (3) step();
    rst_n = 0;
    step();
    check("mrst_tap", 64'(tap), 64'd0);
    check("mrst_sel", sel_n, 64'hFFFF_FFFF_FFFF_FFFE);
    check("mrst_flags", 64'({busy, locked, err}), 64'd0);
    rst_n = 1;
    for (int i = 0; i < 4000; i++) begin
      rst_n = $urandom_range(0, 499) != 0;
      enable = $urandom_range(0, 199) != 0;
      start = $urandom_range(0, 59) == 0;
      pd_valid = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 15) == 0) bias = $urandom_range(0, 100);
      pd_lead = $urandom_range(0, 99) < bias;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
